// File: rtl/seq_gen_10010_tx_if.sv
// Handshake and serial-line bundle for the pattern transmitter.
interface seq_gen_10010_tx_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) ();
  logic             start;
  logic [CNT_W-1:0] repeats;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  // Stimulus side: requests transmissions, watches the line.
  modport master (
    output start, repeats, gap_len, abort,
    input  out, out_valid, frame_end, busy, done
  );

  // Transmitter side.
  modport slave (
    input  start, repeats, gap_len, abort,
    output out, out_valid, frame_end, busy, done
  );
endinterface

// File: rtl/seq_gen_10010_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, a latched number of times, with an
// optional idle gap between repetitions. All outputs are registered.
module seq_gen_10010_tx #(
  parameter int unsigned        PAT_LEN  = 5,
  parameter logic [PAT_LEN-1:0] PATTERN  = 5'b10010,
  parameter int unsigned        CNT_W    = 8,
  parameter int unsigned        GAP_W    = 4,
  parameter logic               IDLE_BIT = 1'b0
) (
  input logic                clk_i,
  input logic                rst_i,
  seq_gen_10010_tx_if.slave  bus
);

  localparam int unsigned   IdxW   = $clog2(PAT_LEN);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(PAT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  // Set on the last bit so the done pulse lands one cycle after it.
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      pend_q    <= 1'b0;
      out_q     <= IDLE_BIT;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output decode; abort overrides everything, including a start.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    pend_d    = 1'b0;
    out_d     = IDLE_BIT;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            // Last bit is on the line this cycle; still busy, so start is not taken here.
            done_d = 1'b1;
          end else if (bus.start && (bus.repeats != '0)) begin
            state_d = StSend;
            idx_d   = IdxMsb;
            rep_d   = bus.repeats;
            gap_d   = bus.gap_len;
          end
        end
        StSend: begin
          out_d   = PATTERN[idx_q];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          fe_d    = (idx_q == '0);
          if (idx_q == '0) begin
            if (rep_q > CNT_W'(1)) begin
              rep_d = rep_q - CNT_W'(1);
              if (gap_q != '0) begin
                state_d   = StGap;
                gap_cnt_d = gap_q;
              end else begin
                idx_d = IdxMsb;
              end
            end else begin
              state_d = StIdle;
              rep_d   = '0;
              pend_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
        StGap: begin
          busy_d    = 1'b1;
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d = StSend;
            idx_d   = IdxMsb;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_end = fe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_gen_10010_tx.sv
// Bench for seq_gen_10010_tx: directed scenarios plus randomized runs, each checked
// cycle by cycle against an expected line trace built from the pattern/repeat/gap rules.
module tb_seq_gen_10010_tx;

  localparam int unsigned PatLen  = 5;
  localparam logic [4:0]  Pat     = 5'b10010;
  localparam logic        IdleBit = 1'b0;
  // Packed as {out, out_valid, frame_end, busy, done}.
  localparam logic [4:0]  IdleVec = {IdleBit, 4'b0000};

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  int run_id = 0;

  logic [4:0] exp_q[$];

  seq_gen_10010_tx_if #(.CNT_W(8), .GAP_W(4)) bus ();

  seq_gen_10010_tx #(
    .PAT_LEN (PatLen),
    .PATTERN (Pat),
    .CNT_W   (8),
    .GAP_W   (4),
    .IDLE_BIT(IdleBit)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {out,vld,fe,busy,done}=%b expected %b", tag, got, exp);
  endtask

  function automatic logic [4:0] line_now();
    return {bus.out, bus.out_valid, bus.frame_end, bus.busy, bus.done};
  endfunction

  // Expected trace after an accepted start: cycle 1 is exp_q[0]. Ends with the done cycle.
  task automatic build_trace(input int r, input int g);
    exp_q.delete();
    for (int i = 0; i < r; i++) begin
      for (int b = PatLen - 1; b >= 0; b--) exp_q.push_back({Pat[b], 1'b1, b == 0, 1'b1, 1'b0});
      if (i < r - 1) for (int k = 0; k < g; k++) exp_q.push_back({IdleBit, 4'b0010});
    end
    if (r > 0) exp_q.push_back({IdleBit, 4'b0001});
  endtask

  // One transmission request. cut_at: cycle in which abort (or rst) is held high (0 = none).
  // restart_at: cycle in which start is pulsed again (0 = none).
  task automatic run(input int r, input int g, input int cut_at, input int restart_at,
                     input bit abort_start, input bit use_rst);
    int n;
    logic [4:0] e;
    run_id++;
    build_trace(abort_start ? 0 : r, g);
    bus.start   = 1'b1;
    bus.repeats = 8'(r);
    bus.gap_len = 4'(g);
    bus.abort   = abort_start;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    // Post-start changes must not matter.
    bus.repeats = 8'($urandom);
    bus.gap_len = 4'($urandom);
    n = exp_q.size() + 2;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (c <= exp_q.size() && (cut_at == 0 || c <= cut_at)) e = exp_q[c-1];
      else e = IdleVec;
      check_val($sformatf("run%0d r%0d g%0d cyc%0d", run_id, r, g, c), line_now(), e);
      bus.start = (c == restart_at);
      if (use_rst) rst = (c == cut_at);
      else bus.abort = (c == cut_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    int r, g, len, cut, rs;
    bus.start   = 1'b0;
    bus.repeats = '0;
    bus.gap_len = '0;
    bus.abort   = 1'b0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset", line_now(), IdleVec);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("after_reset", line_now(), IdleVec);

    run(1, 0, 0, 0, 1'b0, 1'b0);    // single frame
    run(3, 0, 0, 0, 1'b0, 1'b0);    // back-to-back frames
    run(2, 2, 0, 0, 1'b0, 1'b0);    // gap between frames
    run(2, 0, 0, 3, 1'b0, 1'b0);    // start while busy ignored
    run(0, 1, 0, 0, 1'b0, 1'b0);    // zero repeats ignored
    run(2, 0, 3, 0, 1'b0, 1'b0);    // abort on cycle 3
    run(2, 0, 0, 0, 1'b1, 1'b0);    // abort together with start
    run(2, 3, 7, 0, 1'b0, 1'b1);    // rst in the middle of the gap
    run(1, 0, 0, 0, 1'b0, 1'b0);    // clean frame after rst
    run(255, 1, 0, 0, 1'b0, 1'b0);  // full repeat range
    run(2, 15, 0, 0, 1'b0, 1'b0);   // full gap range

    for (int it = 0; it < 40; it++) begin
      r   = $urandom_range(0, 6);
      g   = $urandom_range(0, 15);
      len = (r == 0) ? 0 : r * PatLen + (r - 1) * g + 1;
      cut = 0;
      rs  = 0;
      if (len > 1 && $urandom_range(0, 3) == 0) cut = $urandom_range(1, len - 1);
      else if (len > 1 && $urandom_range(0, 1) == 0) rs = $urandom_range(1, len - 1);
      run(r, g, cut, rs, 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
